// File: rtl/bank_req_responder.sv
// Bank-side responder: round-robin arbitration over PEA request FIFOs and
// execution of the granted word against the local bank SRAM.
module bank_req_responder #(
  parameter int unsigned NUM_PORTS = 16,
  parameter int unsigned WORD_W    = 36,
  parameter int unsigned BANK_ID   = 0,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS*WORD_W-1:0]   req_data,
  input  logic                          bank_stall,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [$clog2(NUM_PORTS)-1:0]  rsp_port,
  output logic [7:0]                    err_cnt,
  output logic [15:0]                   access_cnt
);

  localparam int unsigned PORT_W   = $clog2(NUM_PORTS);
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam int unsigned ID_LSB   = 32;
  localparam int unsigned WE_BIT   = 31;
  localparam int unsigned RSV_LSB  = 24;
  localparam int unsigned ADDR_LSB = 16;

  logic [PORT_W-1:0] rr_ptr;
  logic [PORT_W-1:0] win_idx;
  logic [PORT_W-1:0] cand;
  logic              win_found;
  logic              grant_en;
  logic [WORD_W-1:0] win_word;

  logic              s1_valid;
  logic [3:0]        s1_bank;
  logic              s1_we;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_wdata;
  logic [PORT_W-1:0] s1_port;
  logic              s1_match;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reserved word bits carry no meaning for the bank.
  logic unused_rsvd;
  assign unused_rsvd = ^win_word[RSV_LSB +: 7];

  // Round-robin search starting at rr_ptr, wrapping at NUM_PORTS-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = PORT_W'((32'(rr_ptr) + i) % NUM_PORTS);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant_en = win_found && !bank_stall && rst_n;
  assign gnt      = grant_en ? (NUM_PORTS'(1) << win_idx) : '0;
  assign win_word = req_data[32'(win_idx)*WORD_W +: WORD_W];
  assign s1_match = (s1_bank == 4'(BANK_ID));

  // Arbitration pointer and stage-1 capture of the granted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_bank  <= '0;
      s1_we    <= 1'b0;
      s1_addr  <= '0;
      s1_wdata <= '0;
      s1_port  <= '0;
    end else begin
      s1_valid <= grant_en;
      if (grant_en) begin
        rr_ptr   <= (win_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : win_idx + PORT_W'(1);
        s1_bank  <= win_word[ID_LSB +: 4];
        s1_we    <= win_word[WE_BIT];
        s1_addr  <= win_word[ADDR_LSB +: ADDR_W];
        s1_wdata <= win_word[0 +: DATA_W];
        s1_port  <= win_idx;
      end
    end
  end

  // Stage 2: bank id check, read response and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_port   <= '0;
      err_cnt    <= '0;
      access_cnt <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (s1_valid) begin
        if (!s1_match) begin
          if (err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end else begin
          access_cnt <= access_cnt + 16'd1;
          if (!s1_we) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mem[s1_addr];
            rsp_port  <= s1_port;
          end
        end
      end
    end
  end

  // Bank SRAM; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (s1_valid && s1_match && s1_we) begin
      mem[s1_addr] <= s1_wdata;
    end
  end

endmodule
